// File: rtl/ex_ls_queue_pkg.sv
// ex_ls_queue_pkg: op codes, length/rw codes, free tag and width defaults shared by the LS queue
package ex_ls_queue_pkg;
  localparam int OP_W_DEF = 6;
  localparam int TAG_W_DEF = 4;
  localparam int TAG_FREE = 0;
  localparam int OP_LB = 1;
  localparam int OP_LH = 2;
  localparam int OP_LW = 3;
  localparam int OP_LBU = 4;
  localparam int OP_LHU = 5;
  localparam int OP_SB = 6;
  localparam int OP_SH = 7;
  localparam int OP_SW = 8;
  localparam logic [1:0] LEN_B = 2'b00;
  localparam logic [1:0] LEN_H = 2'b01;
  localparam logic [1:0] LEN_W = 2'b11;
  localparam logic [1:0] RW_NONE = 2'b00;
  localparam logic [1:0] RW_RD = 2'b01;
  localparam logic [1:0] RW_WR = 2'b10;
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  function automatic logic is_load(input int op);
    return op == OP_LB || op == OP_LH || op == OP_LW || op == OP_LBU || op == OP_LHU;
  endfunction
  function automatic logic is_store(input int op);
    return op == OP_SB || op == OP_SH || op == OP_SW;
  endfunction
  function automatic logic [1:0] op_len(input int op);
    return (op == OP_LB || op == OP_LBU || op == OP_SB) ? LEN_B :
           (op == OP_LH || op == OP_LHU || op == OP_SH) ? LEN_H : LEN_W;
  endfunction
endpackage

// File: rtl/ex_ls_queue_fifo.sv
// ls_fifo: synchronous FIFO with push/pop/flush and occupancy; ports clk, rst_n, push, pop, flush, din -> dout, full, empty, count
module ls_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign dout = mem_q[rd_q];
  always_comb begin
    do_pop = pop & !empty;
    do_push = push & (!full | do_pop);
    rd_d = flush ? '0 : rd_q + AW'(do_pop);
    wr_d = flush ? '0 : wr_q + AW'(do_push);
    cnt_d = flush ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/ex_ls_queue.sv
// ex_ls_queue: queued load/store unit issuing one memory transaction at a time; LS_ALIGN_CHECK_EN enables misalignment traps
//   in_*: micro-op push (valid/ready), flush: squash queue, rst_*: load result broadcast,
//   rw_flag/addr/write_data/len: memory request, read_data/mem_busy/mem_done: controller, count: occupancy
module ex_ls_queue import ex_ls_queue_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int TAG_W = TAG_W_DEF,
  parameter int OP_W = OP_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_src1,
  input  logic [DATA_W-1:0]      in_src2,
  input  logic [DATA_W-1:0]      in_reg,
  input  logic [OP_W-1:0]        in_lsop,
  input  logic [TAG_W-1:0]       in_dest,
  input  logic                   flush,
  output logic                   rst_valid,
  output logic [DATA_W-1:0]      rst_data,
  output logic [TAG_W-1:0]       rst_tag,
  output logic                   rst_exc,
  output logic [1:0]             rw_flag,
  output logic [ADDR_W-1:0]      addr,
  output logic [DATA_W-1:0]      write_data,
  output logic [1:0]             len,
  input  logic [DATA_W-1:0]      read_data,
  input  logic                   mem_busy,
  input  logic                   mem_done,
  output logic [$clog2(DEPTH):0] count
);
  localparam int EW = ADDR_W + OP_W + DATA_W + TAG_W;
  state_t state_q, state_d;
  logic [1:0] rw_flag_q, rw_flag_d, len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d, h_addr;
  logic [DATA_W-1:0] wd_q, wd_d, rst_data_q, rst_data_d, h_reg, ext;
  logic [TAG_W-1:0] rst_tag_q, rst_tag_d, cur_tag_q, cur_tag_d, h_tag;
  logic [OP_W-1:0] cur_op_q, cur_op_d, h_op;
  logic rst_valid_q, rst_valid_d, rst_exc_q, rst_exc_d, kill_q, kill_d;
  logic [EW-1:0] head;
  logic full, empty, push, pop, h_ld, h_st, mis, go;
  int h_opi, c_opi;
  assign in_ready = !full;
  assign push = in_valid & !full & !flush;
  assign {h_addr, h_op, h_reg, h_tag} = head;
  ls_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .flush(flush),
    .din({in_src1[ADDR_W-1:0] + in_src2[ADDR_W-1:0], in_lsop, in_reg, in_dest}),
    .dout(head), .full(full), .empty(empty), .count(count)
  );
  always_comb begin
    h_opi = int'(h_op);
    c_opi = int'(cur_op_q);
    h_ld = is_load(h_opi);
    h_st = is_store(h_opi);
`ifdef LS_ALIGN_CHECK_EN
    mis = (h_ld | h_st) && ((op_len(h_opi) == LEN_H && h_addr[0]) || (op_len(h_opi) == LEN_W && h_addr[1:0] != 2'b00));
`else
    mis = 1'b0;
`endif
    ext = c_opi == OP_LB  ? {{(DATA_W-8){read_data[7]}}, read_data[7:0]} :
          c_opi == OP_LH  ? {{(DATA_W-16){read_data[15]}}, read_data[15:0]} :
          c_opi == OP_LBU ? {{(DATA_W-8){1'b0}}, read_data[7:0]} :
          c_opi == OP_LHU ? {{(DATA_W-16){1'b0}}, read_data[15:0]} : read_data;
    go = state_q == S_IDLE && !empty && !mem_busy && !flush;
    state_d = state_q;
    rw_flag_d = RW_NONE;
    addr_d = addr_q;
    len_d = len_q;
    wd_d = wd_q;
    rst_valid_d = 1'b0;
    rst_exc_d = 1'b0;
    rst_tag_d = TAG_W'(TAG_FREE);
    rst_data_d = rst_data_q;
    cur_op_d = cur_op_q;
    cur_tag_d = cur_tag_q;
    kill_d = kill_q;
    pop = 1'b0;
    if (go) begin
      if (!(h_ld | h_st) || mis) begin
        pop = 1'b1;
        rst_valid_d = mis;
        rst_exc_d = mis;
        rst_tag_d = mis ? h_tag : TAG_W'(TAG_FREE);
        rst_data_d = mis ? '0 : rst_data_q;
      end else begin
        state_d = S_WAIT;
        rw_flag_d = h_st ? RW_WR : RW_RD;
        addr_d = h_addr;
        len_d = op_len(h_opi);
        wd_d = h_st ? h_reg : '0;
        cur_op_d = h_op;
        cur_tag_d = h_tag;
        kill_d = 1'b0;
      end
    end else if (state_q == S_WAIT) begin
      if (mem_done) begin
        state_d = S_IDLE;
        addr_d = '0;
        len_d = '0;
        wd_d = '0;
        // a flush during the wait already removed this head from the queue
        pop = !kill_q;
        if (!kill_q && !flush && is_load(c_opi)) begin
          rst_valid_d = 1'b1;
          rst_tag_d = cur_tag_q;
          rst_data_d = ext;
        end
      end else
        kill_d = kill_q | flush;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      rw_flag_q <= RW_NONE;
      addr_q <= '0;
      len_q <= '0;
      wd_q <= '0;
      rst_valid_q <= 1'b0;
      rst_exc_q <= 1'b0;
      rst_tag_q <= TAG_W'(TAG_FREE);
      rst_data_q <= '0;
      cur_op_q <= '0;
      cur_tag_q <= '0;
      kill_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rw_flag_q <= rw_flag_d;
      addr_q <= addr_d;
      len_q <= len_d;
      wd_q <= wd_d;
      rst_valid_q <= rst_valid_d;
      rst_exc_q <= rst_exc_d;
      rst_tag_q <= rst_tag_d;
      rst_data_q <= rst_data_d;
      cur_op_q <= cur_op_d;
      cur_tag_q <= cur_tag_d;
      kill_q <= kill_d;
    end
  assign rw_flag = rw_flag_q;
  assign addr = addr_q;
  assign len = len_q;
  assign write_data = wd_q;
  assign rst_valid = rst_valid_q;
  assign rst_exc = rst_exc_q;
  assign rst_tag = rst_tag_q;
  assign rst_data = rst_data_q;
endmodule

// File: tb/tb_ex_ls_queue.sv
// tb_ex_ls_queue: directed and random stimulus against a queue-based transaction model of ex_ls_queue
module tb_ex_ls_queue;
  import ex_ls_queue_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid, in_ready, flush, rst_valid, rst_exc, mem_busy, mem_done;
  logic [31:0] in_src1, in_src2, in_reg, rst_data, addr, write_data, read_data;
  logic [5:0] in_lsop;
  logic [3:0] in_dest, rst_tag;
  logic [1:0] rw_flag, len;
  logic [2:0] count;
  always #5 clk = ~clk;
  ex_ls_queue dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_src1(in_src1), .in_src2(in_src2), .in_reg(in_reg), .in_lsop(in_lsop), .in_dest(in_dest),
    .flush(flush), .rst_valid(rst_valid), .rst_data(rst_data), .rst_tag(rst_tag), .rst_exc(rst_exc),
    .rw_flag(rw_flag), .addr(addr), .write_data(write_data), .len(len),
    .read_data(read_data), .mem_busy(mem_busy), .mem_done(mem_done), .count(count)
  );
  typedef struct {logic [31:0] a; int op; logic [31:0] d; logic [3:0] t;} ent_t;
  ent_t q[$];
  ent_t cur;
  bit busy, killed;
  logic [1:0] e_rw, e_len;
  logic [31:0] e_addr, e_wd, e_rd;
  logic e_rv, e_exc;
  logic [3:0] e_rt;
  int checks = 0, passes = 0, fails = 0;
  int ops[10] = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW, 0, 63};
  function automatic bit m_ld(int op);
    return op == OP_LB || op == OP_LH || op == OP_LW || op == OP_LBU || op == OP_LHU;
  endfunction
  function automatic bit m_st(int op);
    return op == OP_SB || op == OP_SH || op == OP_SW;
  endfunction
  function automatic int m_size(int op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    return 4;
  endfunction
  function automatic bit m_mis(ent_t e);
`ifdef LS_ALIGN_CHECK_EN
    return (e.a % m_size(e.op)) != 0;
`else
    return e.a === 32'hx;
`endif
  endfunction
  function automatic logic [31:0] m_ext(int op, logic [31:0] rd);
    int v;
    if (op == OP_LB) begin v = $signed(rd[7:0]); return v; end
    if (op == OP_LH) begin v = $signed(rd[15:0]); return v; end
    if (op == OP_LBU) return rd & 32'hFF;
    if (op == OP_LHU) return rd & 32'hFFFF;
    return rd;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag);
    chk({tag, ".rw_flag"}, 32'(rw_flag), 32'(e_rw));
    chk({tag, ".addr"}, addr, e_addr);
    chk({tag, ".write_data"}, write_data, e_wd);
    chk({tag, ".len"}, 32'(len), 32'(e_len));
    chk({tag, ".rst_valid"}, 32'(rst_valid), 32'(e_rv));
    chk({tag, ".rst_data"}, rst_data, e_rd);
    chk({tag, ".rst_tag"}, 32'(rst_tag), 32'(e_rt));
    chk({tag, ".rst_exc"}, 32'(rst_exc), 32'(e_exc));
    chk({tag, ".count"}, 32'(count), 32'(q.size()));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(q.size() < 4));
  endtask
  task automatic model_reset();
    q.delete();
    busy = 0;
    killed = 0;
    e_rw = 0; e_addr = 0; e_wd = 0; e_len = 0;
    e_rv = 0; e_rd = 0; e_rt = 4'(TAG_FREE); e_exc = 0;
  endtask
  task automatic cyc(input string tag);
    int n0;
    ent_t h, n;
    n0 = q.size();
    @(posedge clk);
    e_rw = 0; e_rv = 0; e_exc = 0; e_rt = 4'(TAG_FREE);
    if (!busy) begin
      if (n0 > 0 && !mem_busy && !flush) begin
        h = q[0];
        if (!m_ld(h.op) && !m_st(h.op)) void'(q.pop_front());
        else if (m_mis(h)) begin
          void'(q.pop_front());
          e_rv = 1; e_exc = 1; e_rd = 0; e_rt = h.t;
        end else begin
          cur = h; busy = 1; killed = 0;
          e_rw = m_st(h.op) ? 2'b10 : 2'b01;
          e_addr = h.a;
          e_len = m_size(h.op) == 1 ? 2'b00 : m_size(h.op) == 2 ? 2'b01 : 2'b11;
          e_wd = m_st(h.op) ? h.d : 0;
        end
      end
    end else if (mem_done) begin
      if (!killed && !flush) begin
        void'(q.pop_front());
        if (m_ld(cur.op)) begin e_rv = 1; e_rt = cur.t; e_rd = m_ext(cur.op, read_data); end
      end
      busy = 0; e_addr = 0; e_len = 0; e_wd = 0;
    end else if (flush) killed = 1;
    if (flush) q.delete();
    else if (in_valid && n0 < 4) begin
      n.a = in_src1 + in_src2; n.op = int'(in_lsop); n.d = in_reg; n.t = in_dest;
      q.push_back(n);
    end
    #1;
    chk_all(tag);
  endtask
  task automatic drive(input string tag, input bit v, input logic [31:0] s1, input logic [31:0] s2,
                       input logic [31:0] rg, input int op, input logic [3:0] dst,
                       input bit fl, input bit mb, input bit md, input logic [31:0] rd);
    in_valid = v; in_src1 = s1; in_src2 = s2; in_reg = rg; in_lsop = 6'(op); in_dest = dst;
    flush = fl; mem_busy = mb; mem_done = md; read_data = rd;
    cyc(tag);
  endtask
  task automatic idle(input string tag, input bit md, input logic [31:0] rd);
    drive(tag, 0, 0, 0, 0, 0, 0, 0, 0, md, rd);
  endtask
  initial begin
    in_valid = 0; in_src1 = 0; in_src2 = 0; in_reg = 0; in_lsop = 0; in_dest = 0;
    flush = 0; mem_busy = 0; mem_done = 0; read_data = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    rst_n = 1;
    drive("lb_push", 1, 32'h100, 0, 0, OP_LB, 4'd3, 0, 0, 0, 0);
    idle("lb_issue", 0, 0);
    chk("lb_rw", 32'(rw_flag), 32'h1);
    idle("lb_wait", 0, 0);
    idle("lb_done", 1, 32'h0000_00F0);
    chk("lb_data", rst_data, 32'hFFFF_FFF0);
    chk("lb_tag", 32'(rst_tag), 32'h3);
    drive("lbu_push", 1, 32'h100, 0, 0, OP_LBU, 4'd6, 0, 0, 0, 0);
    idle("lbu_issue", 0, 0);
    idle("lbu_done", 1, 32'h0000_00F0);
    chk("lbu_data", rst_data, 32'h0000_00F0);
    drive("sw_push", 1, 32'h200, 32'h4, 32'hDEAD_BEEF, OP_SW, 4'd5, 0, 0, 0, 0);
    idle("sw_issue", 0, 0);
    chk("sw_rw", 32'(rw_flag), 32'h2);
    chk("sw_addr", addr, 32'h204);
    chk("sw_len", 32'(len), 32'h3);
    chk("sw_wd", write_data, 32'hDEAD_BEEF);
    idle("sw_wait", 0, 0);
    chk("sw_rw_pulse", 32'(rw_flag), 32'h0);
    idle("sw_done", 1, 32'h1234_5678);
    chk("sw_no_result", 32'(rst_valid), 32'h0);
    drive("unk_push", 1, 32'h40, 0, 0, 63, 4'd2, 0, 0, 0, 0);
    idle("unk_drop", 0, 0);
    drive("mis_push", 1, 32'h100, 32'h2, 0, OP_LW, 4'd7, 0, 0, 0, 0);
    idle("mis_issue", 0, 0);
    idle("mis_done", 1, 32'hCAFE_F00D);
    for (int i = 1; i <= 5; i++) begin
      drive("fill", 1, 32'h10 * i, 0, 0, OP_LW, 4'(i), 0, 1, 0, 32'(i));
      if (i == 4) begin
        chk("full_count", 32'(count), 32'h4);
        chk("full_ready", 32'(in_ready), 32'h0);
      end
    end
    drive("full_issue", 1, 32'h60, 0, 0, OP_LH, 4'd6, 0, 0, 0, 0);
    drive("full_pop", 1, 32'h60, 0, 0, OP_LH, 4'd6, 0, 0, 1, 32'h0000_8001);
    drive("popush", 1, 32'h70, 0, 0, OP_LHU, 4'd7, 0, 0, 0, 0);
    for (int i = 0; i < 40 && (busy || q.size() > 0); i++) idle("drain", busy, 32'h8000_0000 + 32'(i));
    chk("drain_count", 32'(count), 32'h0);
    drive("fl_a", 1, 32'h300, 0, 0, OP_LW, 4'd1, 0, 0, 0, 0);
    drive("fl_b", 1, 32'h304, 0, 0, OP_LW, 4'd2, 0, 0, 0, 0);
    drive("fl_c", 1, 32'h308, 0, 0, OP_LW, 4'd3, 0, 0, 0, 0);
    drive("fl_d", 1, 32'h30C, 0, 0, OP_LW, 4'd4, 0, 0, 0, 0);
    drive("flush", 1, 32'h310, 0, 0, OP_LW, 4'd5, 1, 0, 0, 0);
    chk("flush_count", 32'(count), 32'h0);
    drive("fl_push", 1, 32'h400, 0, 0, OP_LB, 4'd9, 0, 0, 0, 0);
    idle("fl_done", 1, 32'h77);
    chk("flush_no_result", 32'(rst_valid), 32'h0);
    idle("fl_reissue", 0, 0);
    chk("flush_reissue", 32'(rw_flag), 32'h1);
    idle("fl_last", 1, 32'h81);
    drive("rst_push", 1, 32'h500, 0, 0, OP_LW, 4'd4, 0, 0, 0, 0);
    idle("rst_issue", 0, 0);
    rst_n = 0;
    model_reset();
    #1;
    chk_all("rst_mid");
    rst_n = 1;
    idle("rst_stray", 1, 32'h55);
    for (int i = 0; i < 500; i++) begin
      int op;
      op = ops[$urandom_range(9)];
      drive("rand", $urandom_range(1), $urandom_range(32'hFFF), $urandom_range(7), $urandom, op,
            4'($urandom_range(15)), $urandom_range(15) == 0, $urandom_range(3) == 0,
            busy ? $urandom_range(2) == 0 : $urandom_range(7) == 0, $urandom);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
